// File: rtl/lim_rt_ctrl.sv
// Sequencer for one logic-in-memory racetrack bank: shift the word to the port, access it (plain or LiM), shift back.
// Grant is combinational from req_i; a new request is taken in idle or in the last cycle of the previous one.
module lim_rt_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_W    = 5,
  parameter int LIM_WAIT   = 3
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [7:0]              funct_i,
  input  logic [SHIFT_W-1:0]      shift_amt_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    shift_en_o,
  output logic                    shift_dir_o,
  output logic                    w_en_d_o,
  output logic                    w_en_m_o,
  output logic                    w_en_p_o,
  output logic                    r_en_o,
  output logic                    nand_nor_o,
  output logic                    bz_o,
  output logic                    out_sel_o
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [7:0] FUNCT_NULL = 8'h00;
  localparam logic [7:0] FUNCT_AND  = 8'h01;
  localparam logic [7:0] FUNCT_OR   = 8'h02;
  localparam logic [7:0] FUNCT_XOR  = 8'h03;
  localparam logic [7:0] FUNCT_NAND = 8'h04;
  localparam logic [7:0] FUNCT_NOR  = 8'h05;

  localparam logic [3:0]         LIM_CYC = 4'(LIM_WAIT);
  localparam logic [SHIFT_W-1:0] ONE_SH  = SHIFT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_SET,
    S_ACCESS,
    S_MASK,
    S_LIM,
    S_LIM_ACCESS,
    S_SHIFT_RESET,
    S_ERR
  } state_t;

  // Everything about the accepted request that later states need.
  typedef struct packed {
    logic               we;
    logic [NB-1:0]      be;
    logic               lim;
    logic               nand_cls;
    logic [SHIFT_W-1:0] amt;
  } req_t;

  state_t             r_state;
  state_t             w_state_nxt;
  req_t               r_req;
  logic [SHIFT_W-1:0] r_shift_cnt;
  logic [3:0]         r_lim_cnt;

  logic   w_in_nand;
  logic   w_in_nor;
  logic   w_in_plain;
  logic   w_in_err;
  state_t w_entry_state;
  logic   w_accept_slot;
  logic   w_gnt;
  logic   w_partial;
  logic   w_shift_last;

  // Decode of the incoming request; only meaningful in a cycle where it is granted.
  always_comb begin
    w_in_nand  = (funct_i == FUNCT_AND)  || (funct_i == FUNCT_NAND);
    w_in_nor   = (funct_i == FUNCT_OR)   || (funct_i == FUNCT_NOR);
    w_in_plain = (funct_i == FUNCT_NULL) || (funct_i == FUNCT_XOR);
    w_in_err   = !(w_in_nand || w_in_nor || w_in_plain) || (we_i && (be_i == '0));
  end

  always_comb begin
    w_entry_state = S_ACCESS;
    if (w_in_err) begin
      w_entry_state = S_ERR;
    end else if (shift_amt_i != '0) begin
      w_entry_state = S_SHIFT_SET;
    end else if (w_in_nand || w_in_nor) begin
      w_entry_state = S_MASK;
    end
  end

  assign w_shift_last = (r_shift_cnt == ONE_SH);
  assign w_partial    = r_req.we && (r_req.be != '1) && (r_req.be != '0);

  // A request can chain in the last cycle of the current one so the bank never idles between them.
  always_comb begin
    w_accept_slot = 1'b0;
    case (r_state)
      S_IDLE:        w_accept_slot = 1'b1;
      S_SHIFT_RESET: w_accept_slot = w_shift_last;
      S_ACCESS,
      S_LIM_ACCESS:  w_accept_slot = (r_req.amt == '0);
      default:       w_accept_slot = 1'b0;
    endcase
  end

  assign w_gnt = req_i && rstn_i && w_accept_slot;
  assign gnt_o = w_gnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gnt) w_state_nxt = w_entry_state;
      end
      S_SHIFT_SET: begin
        if (w_shift_last) w_state_nxt = r_req.lim ? S_MASK : S_ACCESS;
      end
      S_ACCESS,
      S_LIM_ACCESS: begin
        if (r_req.amt != '0) begin
          w_state_nxt = S_SHIFT_RESET;
        end else begin
          w_state_nxt = w_gnt ? w_entry_state : S_IDLE;
        end
      end
      S_MASK: w_state_nxt = S_LIM;
      S_LIM: begin
        if (r_lim_cnt == 4'd1) w_state_nxt = S_LIM_ACCESS;
      end
      S_SHIFT_RESET: begin
        if (w_shift_last) w_state_nxt = w_gnt ? w_entry_state : S_IDLE;
      end
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_req <= '0;
    end else if (w_gnt) begin
      r_req.we       <= we_i;
      r_req.be       <= be_i;
      r_req.lim      <= w_in_nand || w_in_nor;
      r_req.nand_cls <= w_in_nand;
      r_req.amt      <= shift_amt_i;
    end
  end

  // Shift counter runs down through SHIFT_SET, then is reloaded from the latched amount for the return trip.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_shift_cnt <= '0;
    end else if (w_gnt) begin
      r_shift_cnt <= shift_amt_i;
    end else if ((r_state == S_ACCESS) || (r_state == S_LIM_ACCESS)) begin
      r_shift_cnt <= r_req.amt;
    end else if ((r_state == S_SHIFT_SET) || (r_state == S_SHIFT_RESET)) begin
      r_shift_cnt <= r_shift_cnt - ONE_SH;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_lim_cnt <= '0;
    end else if (r_state == S_MASK) begin
      r_lim_cnt <= LIM_CYC;
    end else if (r_state == S_LIM) begin
      r_lim_cnt <= r_lim_cnt - 4'd1;
    end
  end

  always_comb begin
    rvalid_o    = 1'b0;
    err_o       = 1'b0;
    shift_en_o  = 1'b0;
    shift_dir_o = 1'b0;
    w_en_d_o    = 1'b0;
    w_en_m_o    = 1'b0;
    w_en_p_o    = 1'b0;
    r_en_o      = 1'b0;
    nand_nor_o  = 1'b0;
    bz_o        = 1'b0;
    out_sel_o   = 1'b0;
    busy_o      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: shift_dir_o = 1'b1;
      S_SHIFT_SET: begin
        shift_en_o  = 1'b1;
        shift_dir_o = 1'b1;
      end
      S_SHIFT_RESET: shift_en_o = 1'b1;
      S_ACCESS: begin
        rvalid_o = 1'b1;
        w_en_d_o = r_req.we;
        r_en_o   = r_req.we ? w_partial : 1'b1;
      end
      // Partial writes read the old word alongside the mask write so unselected bytes survive.
      S_MASK: begin
        w_en_m_o   = 1'b1;
        w_en_p_o   = 1'b1;
        r_en_o     = w_partial;
        nand_nor_o = r_req.nand_cls;
      end
      S_LIM: begin
        bz_o       = 1'b1;
        nand_nor_o = r_req.nand_cls;
      end
      S_LIM_ACCESS: begin
        out_sel_o = 1'b1;
        r_en_o    = 1'b1;
        rvalid_o  = 1'b1;
        w_en_d_o  = r_req.we;
      end
      S_ERR: begin
        rvalid_o = 1'b1;
        err_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
